// File: rtl/rob_tagged.sv
// Tagged reorder buffer: in-order allocation and retirement, out-of-order completion
// from an ALU port and a load/store-buffer port, with a registered mispredict redirect.
module rob_tagged #(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int RD_W   = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              alloc_valid,
  input  logic [RD_W-1:0]   alloc_rd,
  input  logic [DATA_W-1:0] alloc_pc,
  output logic              alloc_ready,
  output logic [PTR_W-1:0]  alloc_tag,

  input  logic              alu_wb_valid,
  input  logic [PTR_W-1:0]  alu_wb_tag,
  input  logic [DATA_W-1:0] alu_wb_data,
  input  logic [DATA_W-1:0] alu_wb_jpc,

  input  logic              slb_wb_valid,
  input  logic [PTR_W-1:0]  slb_wb_tag,
  input  logic [DATA_W-1:0] slb_wb_data,

  output logic              commit_valid,
  output logic [PTR_W-1:0]  commit_tag,
  output logic [RD_W-1:0]   commit_rd,
  output logic [DATA_W-1:0] commit_pc,
  output logic [DATA_W-1:0] commit_data,

  output logic              flush,
  output logic [DATA_W-1:0] flush_pc,

  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [DATA_W-1:0] INSN_BYTES = DATA_W'(4);

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  finish;
  logic [RD_W-1:0]   rd_q   [DEPTH];
  logic [DATA_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] jpc_q  [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  logic              alloc_fire;
  logic              commit_fire;
  logic              alu_hit;
  logic              slb_hit;
  logic              mispredict;
  logic [DATA_W-1:0] head_pc;
  logic [DATA_W-1:0] head_jpc;

  // Handshake and retirement decisions; everything is gated off during the flush cycle.
  always_comb begin
    alloc_ready = (count < FULL_COUNT) && !flush;
    alloc_tag   = tail;
    alloc_fire  = alloc_valid && alloc_ready;
    commit_fire = (count != '0) && finish[head] && !flush;
    alu_hit     = alu_wb_valid && busy[alu_wb_tag] && !flush;
    slb_hit     = slb_wb_valid && busy[slb_wb_tag] && !flush &&
                  !(alu_hit && (alu_wb_tag == slb_wb_tag));
    head_pc     = pc_q[head];
    head_jpc    = jpc_q[head];
    mispredict  = head_jpc != (head_pc + INSN_BYTES);
  end

  // Control state, pointers and registered commit/redirect outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= '0;
      finish       <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_tag   <= '0;
      commit_rd    <= '0;
      commit_pc    <= '0;
      commit_data  <= '0;
      flush        <= 1'b0;
      flush_pc     <= '0;
    end else if (flush) begin
      busy         <= '0;
      finish       <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      flush        <= 1'b0;
    end else begin
      commit_valid <= commit_fire;
      flush        <= commit_fire && mispredict;

      if (alloc_fire) begin
        busy[tail]   <= 1'b1;
        finish[tail] <= 1'b0;
        tail         <= tail + 1'b1;
      end

      if (alu_hit) finish[alu_wb_tag] <= 1'b1;
      if (slb_hit) finish[slb_wb_tag] <= 1'b1;

      // Retirement clears the head slot last so it overrides any late writeback to it.
      if (commit_fire) begin
        busy[head]   <= 1'b0;
        finish[head] <= 1'b0;
        head         <= head + 1'b1;
        commit_tag   <= head;
        commit_rd    <= rd_q[head];
        commit_pc    <= head_pc;
        commit_data  <= data_q[head];
        if (mispredict) flush_pc <= head_jpc;
      end

      count <= count + (PTR_W+1)'(alloc_fire) - (PTR_W+1)'(commit_fire);
    end
  end

  // Payload storage needs no reset: busy/finish qualify every read.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      rd_q[tail]  <= alloc_rd;
      pc_q[tail]  <= alloc_pc;
      jpc_q[tail] <= alloc_pc + INSN_BYTES;
    end
    if (alu_hit) begin
      data_q[alu_wb_tag] <= alu_wb_data;
      jpc_q[alu_wb_tag]  <= alu_wb_jpc;
    end
    if (slb_hit) begin
      data_q[slb_wb_tag] <= slb_wb_data;
    end
  end

endmodule

// File: tb/tb_rob_tagged.sv
// Directed self-checking bench for rob_tagged: in-order retirement, full/blocked alloc,
// mispredict flush, writeback port priority, tag wrap and mid-operation reset.
module tb_rob_tagged;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = 4;
  localparam int RD_W   = 5;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              alloc_valid;
  logic [RD_W-1:0]   alloc_rd;
  logic [DATA_W-1:0] alloc_pc;
  logic              alloc_ready;
  logic [PTR_W-1:0]  alloc_tag;
  logic              alu_wb_valid;
  logic [PTR_W-1:0]  alu_wb_tag;
  logic [DATA_W-1:0] alu_wb_data;
  logic [DATA_W-1:0] alu_wb_jpc;
  logic              slb_wb_valid;
  logic [PTR_W-1:0]  slb_wb_tag;
  logic [DATA_W-1:0] slb_wb_data;
  logic              commit_valid;
  logic [PTR_W-1:0]  commit_tag;
  logic [RD_W-1:0]   commit_rd;
  logic [DATA_W-1:0] commit_pc;
  logic [DATA_W-1:0] commit_data;
  logic              flush;
  logic [DATA_W-1:0] flush_pc;
  logic [PTR_W:0]    count;

  int nTests = 0;
  int nFail  = 0;

  rob_tagged #(.DEPTH(DEPTH), .PTR_W(PTR_W), .RD_W(RD_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alu_wb_valid(alu_wb_valid), .alu_wb_tag(alu_wb_tag),
    .alu_wb_data(alu_wb_data), .alu_wb_jpc(alu_wb_jpc),
    .slb_wb_valid(slb_wb_valid), .slb_wb_tag(slb_wb_tag), .slb_wb_data(slb_wb_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_pc(commit_pc), .commit_data(commit_data),
    .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [DATA_W-1:0] apc, input logic [RD_W-1:0] ard,
                               input logic aw, input logic [PTR_W-1:0] at, input logic [DATA_W-1:0] ad,
                               input logic [DATA_W-1:0] aj,
                               input logic sw, input logic [PTR_W-1:0] st, input logic [DATA_W-1:0] sd);
    alloc_valid  = av;  alloc_pc    = apc; alloc_rd    = ard;
    alu_wb_valid = aw;  alu_wb_tag  = at;  alu_wb_data = ad;  alu_wb_jpc = aj;
    slb_wb_valid = sw;  slb_wb_tag  = st;  slb_wb_data = sd;
  endtask

  task automatic idle();
    applyStimulus(0, '0, '0, 0, '0, '0, '0, 0, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_ready", alloc_ready, 1);
  endtask

  task automatic allocOne(input logic [DATA_W-1:0] pc, input logic [RD_W-1:0] rd, input int expTag);
    applyStimulus(1, pc, rd, 0, '0, '0, '0, 0, '0, '0);
    checkOutput("alloc_tag", alloc_tag, expTag);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] expPc[$];
    logic [DATA_W-1:0] prevPc;
    logic [PTR_W-1:0]  prevTag;
    logic              prevValid;
    logic              fired;
    int                nAlloc;
    int                nCommit;

    // Reset state, before any clock edge
    rst = 1'b1;
    idle();
    #1;
    checkOutput("r0_ready", alloc_ready, 1);
    checkOutput("r0_tag", alloc_tag, 0);
    checkOutput("r0_count", count, 0);
    checkOutput("r0_cv", commit_valid, 0);
    checkOutput("r0_flush", flush, 0);
    tick();
    rst = 1'b0;

    // In-order retirement with out-of-order ALU completion
    allocOne(32'h100, 5'd1, 0);
    allocOne(32'h104, 5'd2, 1);
    allocOne(32'h108, 5'd3, 2);
    checkOutput("t1_count3", count, 3);
    applyStimulus(0, '0, '0, 1, 4'd2, 32'h22, 32'h10C, 0, '0, '0);
    tick();
    applyStimulus(0, '0, '0, 1, 4'd0, 32'h11, 32'h104, 0, '0, '0);
    tick();
    checkOutput("t1_latency", commit_valid, 0);
    applyStimulus(0, '0, '0, 1, 4'd1, 32'h33, 32'h108, 0, '0, '0);
    tick();
    idle();
    checkOutput("t1_c0_valid", commit_valid, 1);
    checkOutput("t1_c0_pc", commit_pc, 32'h100);
    checkOutput("t1_c0_data", commit_data, 32'h11);
    checkOutput("t1_c0_rd", commit_rd, 1);
    checkOutput("t1_c0_flush", flush, 0);
    tick();
    checkOutput("t1_c1_pc", commit_pc, 32'h104);
    checkOutput("t1_c1_data", commit_data, 32'h33);
    checkOutput("t1_c1_tag", commit_tag, 1);
    checkOutput("t1_c1_flush", flush, 0);
    tick();
    checkOutput("t1_c2_pc", commit_pc, 32'h108);
    checkOutput("t1_c2_data", commit_data, 32'h22);
    checkOutput("t1_c2_flush", flush, 0);
    tick();
    checkOutput("t1_done_cv", commit_valid, 0);
    checkOutput("t1_done_count", count, 0);

    // Fill to DEPTH, blocked 17th alloc, blocked alloc during commit, then tag 0 reused
    resetDut();
    for (int i = 0; i < DEPTH; i++) allocOne(32'h1000 + 4 * i, RD_W'(i), i);
    checkOutput("t2_full_count", count, 16);
    checkOutput("t2_full_ready", alloc_ready, 0);
    applyStimulus(1, 32'hDEAD, 5'd9, 0, '0, '0, '0, 0, '0, '0);
    tick();
    checkOutput("t2_17th_count", count, 16);
    applyStimulus(0, '0, '0, 1, 4'd0, 32'h77, 32'h1004, 0, '0, '0);
    tick();
    applyStimulus(1, 32'hBEEF, 5'd7, 0, '0, '0, '0, 0, '0, '0);
    checkOutput("t2_full_ready2", alloc_ready, 0);
    tick();
    checkOutput("t2_commit_valid", commit_valid, 1);
    checkOutput("t2_commit_pc", commit_pc, 32'h1000);
    checkOutput("t2_commit_data", commit_data, 32'h77);
    checkOutput("t2_blocked_count", count, 15);
    checkOutput("t2_ready_again", alloc_ready, 1);
    checkOutput("t2_next_tag", alloc_tag, 0);
    tick();
    idle();
    checkOutput("t2_refill_count", count, 16);
    checkOutput("t2_refill_tag", alloc_tag, 1);

    // Mispredict: commit and flush together, then empty
    resetDut();
    allocOne(32'h200, 5'd4, 0);
    allocOne(32'h204, 5'd5, 1);
    applyStimulus(0, '0, '0, 1, 4'd0, 32'h55, 32'h300, 0, '0, '0);
    tick();
    idle();
    tick();
    checkOutput("t3_cv", commit_valid, 1);
    checkOutput("t3_pc", commit_pc, 32'h200);
    checkOutput("t3_flush", flush, 1);
    checkOutput("t3_flush_pc", flush_pc, 32'h300);
    checkOutput("t3_ready_in_flush", alloc_ready, 0);
    applyStimulus(1, 32'h900, 5'd1, 1, 4'd1, 32'h66, 32'h208, 0, '0, '0);
    tick();
    idle();
    checkOutput("t3_after_count", count, 0);
    checkOutput("t3_after_cv", commit_valid, 0);
    checkOutput("t3_after_flush", flush, 0);
    checkOutput("t3_after_tag", alloc_tag, 0);
    tick();
    checkOutput("t3_no_stray_commit", commit_valid, 0);

    // Writeback ports: SLB completion, and ALU priority on same tag
    resetDut();
    for (int i = 0; i < 4; i++) allocOne(32'h400 + 4 * i, RD_W'(i + 8), i);
    applyStimulus(0, '0, '0, 1, 4'd0, 32'h10, 32'h404, 1, 4'd1, 32'h61);
    tick();
    applyStimulus(0, '0, '0, 1, 4'd3, 32'hAA, 32'h410, 1, 4'd3, 32'hBB);
    tick();
    checkOutput("t4_c0_data", commit_data, 32'h10);
    applyStimulus(0, '0, '0, 1, 4'd2, 32'h22, 32'h40C, 0, '0, '0);
    tick();
    idle();
    checkOutput("t4_c1_data", commit_data, 32'h61);
    checkOutput("t4_c1_flush", flush, 0);
    tick();
    checkOutput("t4_c2_data", commit_data, 32'h22);
    tick();
    checkOutput("t4_c3_tag", commit_tag, 3);
    checkOutput("t4_c3_data", commit_data, 32'hAA);
    checkOutput("t4_c3_flush", flush, 0);

    // 40 alloc/commit pairs with tag wrap and in-order scoreboard
    resetDut();
    nAlloc = 0;
    nCommit = 0;
    prevValid = 1'b0;
    prevTag = '0;
    prevPc = '0;
    for (int cyc = 0; cyc < 400 && nCommit < 40; cyc++) begin
      applyStimulus(nAlloc < 40, 32'h2000 + 4 * nAlloc, RD_W'(nAlloc),
                    prevValid, prevTag, prevPc ^ 32'h5A5A, prevPc + 4, 0, '0, '0);
      fired = alloc_valid && alloc_ready;
      if (fired) checkOutput("t5_alloc_tag", alloc_tag, nAlloc % DEPTH);
      prevTag = alloc_tag;
      tick();
      if (fired) begin
        expPc.push_back(alloc_pc);
        prevPc = alloc_pc;
        prevValid = 1'b1;
        nAlloc++;
      end else begin
        prevValid = 1'b0;
      end
      checkOutput("t5_count_max", count <= 16, 1);
      if (commit_valid) begin
        checkOutput("t5_commit_tag", commit_tag, nCommit % DEPTH);
        checkOutput("t5_commit_pc", commit_pc, expPc.pop_front());
        checkOutput("t5_commit_flush", flush, 0);
        nCommit++;
      end
    end
    checkOutput("t5_commit_total", nCommit, 40);
    idle();
    tick();

    // Mid-operation reset with live and finished entries (head/tail now at 8)
    for (int i = 0; i < 5; i++) allocOne(32'h3000 + 4 * i, RD_W'(i), 8 + i);
    applyStimulus(0, '0, '0, 1, 4'd8, 32'h88, 32'h3004, 1, 4'd9, 32'h99);
    tick();
    idle();
    checkOutput("t6_pre_count", count, 5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_count", count, 0);
    checkOutput("t6_rst_tag", alloc_tag, 0);
    checkOutput("t6_rst_ready", alloc_ready, 1);
    checkOutput("t6_rst_cv", commit_valid, 0);
    checkOutput("t6_rst_cpc", commit_pc, 0);
    checkOutput("t6_rst_ctag", commit_tag, 0);
    checkOutput("t6_rst_cdata", commit_data, 0);
    checkOutput("t6_rst_flush", flush, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t6_no_commit", commit_valid, 0);
    end
    allocOne(32'h4000, 5'd2, 0);
    idle();
    checkOutput("t6_new_count", count, 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/rob_tagged.md
ROB_TAGGED -- requirements
Module: rob_tagged

Interface
REQ-001 SHALL have parameter DEPTH, 16, entry count; power of two, >= 4.
REQ-002 SHALL have parameter PTR_W, 4, log2(DEPTH); tag and pointer width.
REQ-003 SHALL have parameter RD_W, 5, destination register index width.
REQ-004 SHALL have parameter DATA_W, 32, result data width; PC width also DATA_W.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports alloc_valid in 1, alloc_rd in RD_W, alloc_pc in DATA_W: allocation request from decoder.
REQ-008 SHALL have ports alloc_ready out 1 and alloc_tag out PTR_W: slot available; tag assigned to this allocation (= tail).
REQ-009 SHALL have ports alu_wb_valid in 1, alu_wb_tag in PTR_W, alu_wb_data in DATA_W, alu_wb_jpc in DATA_W: ALU completion.
REQ-010 SHALL have ports slb_wb_valid in 1, slb_wb_tag in PTR_W, slb_wb_data in DATA_W: load/store buffer completion.
REQ-011 SHALL have ports commit_valid out 1, commit_tag out PTR_W, commit_rd out RD_W, commit_pc out DATA_W, commit_data out DATA_W: registered commit.
REQ-012 SHALL have ports flush out 1, flush_pc out DATA_W: registered mispredict redirect.
REQ-013 SHALL have port count out PTR_W+1: live entries, 0..DEPTH.

Function
REQ-014 SHALL store per entry: busy, finish, rd, pc, data, jpc; head/tail pointers wrap modulo DEPTH.
REQ-015 SHALL drive alloc_ready = (count < DEPTH) && !flush, combinationally; all DEPTH slots usable (no spare slot).
REQ-016 SHALL, on alloc_valid && alloc_ready, write entry[tail]: busy=1, finish=0, rd, pc, jpc=alloc_pc+4 (mod 2^DATA_W); tail+1.
REQ-017 SHALL ignore alloc_valid when alloc_ready=0; alloc while full is blocked even if a commit occurs same cycle.
REQ-018 SHALL, on alu_wb_valid to a busy entry, set finish=1, data=alu_wb_data, jpc=alu_wb_jpc.
REQ-019 SHALL, on slb_wb_valid to a busy entry, set finish=1, data=slb_wb_data; jpc unchanged.
REQ-020 SHALL ignore writebacks to non-busy tags; same tag on both ports same cycle: ALU wins.
REQ-021 SHALL commit head when count!=0, entry[head].finish=1 (stored value) and flush=0; max one commit per cycle.
REQ-022 SHALL on commit edge register commit_valid=1 and head fields, clear entry[head].busy, head+1; else commit_valid=0 next cycle.
REQ-023 SHALL commit an entry no earlier than the cycle after its writeback edge (writeback-to-commit_valid latency 2 edges minimum at head).
REQ-024 SHALL on commit edge set flush=1, flush_pc=entry jpc iff jpc != pc+4; else flush=0.
REQ-025 SHALL on the edge where flush=1 clear all busy/finish, head=tail=count=0, commit_valid=0, flush=0; ignore alloc and writebacks that cycle.
REQ-026 SHALL update count = count + alloc_fire - commit_fire; simultaneous alloc and commit leaves count unchanged.
REQ-027 SHALL assert commit_valid and flush together for the mispredicting instruction (its result still retires).

Reset
REQ-028 SHALL on rst=1 immediately clear: head, tail, count, all busy/finish, commit_valid, commit_tag, commit_rd, commit_pc, commit_data, flush, flush_pc to 0.
REQ-029 SHALL drive alloc_ready=1 and alloc_tag=0 while and after reset; reset mid-operation discards all entries with no commit.

Verification
REQ-030 Alloc pc 0x100,0x104,0x108 (tags 0,1,2); ALU wb tags 2,0,1 with jpc=pc+4 -> commits in order pcs 0x100,0x104,0x108, flush never 1.
REQ-031 Alloc 16 entries with DEPTH=16 -> count=16, alloc_ready=0; 17th alloc_valid ignored; one commit -> alloc_ready=1 next cycle, next tag 0.
REQ-032 Alloc pc 0x200 (tag 0) and 0x204; ALU wb tag 0 jpc=0x300 -> commit_valid=1 pc 0x200 with flush=1 flush_pc=0x300; next cycle count=0, commit_valid=0.
REQ-033 ALU and SLB wb same tag 3 data 0xAA / 0xBB same cycle -> tag 3 commits data 0xAA.
REQ-034 Run 40 alloc/commit pairs through DEPTH=16 -> tags wrap 15->0, commit order equals alloc order, count never exceeds 16.
REQ-035 Assert rst with 5 entries live, 2 finished -> outputs 0 immediately, no commit_valid after release, first new alloc gets tag 0.
